// File: rtl/axis_video_src.sv
// Test-pattern AXI4-Stream video master: colour bars, gradient, checkerboard or solid frames with SOF on tuser and EOL on tlast.
// Latency: first pixel is valid one cycle after src_enable is seen in IDLE; one new pixel per accepted beat after that.
// Backpressure: registered outputs hold while tvalid && !tready; there is no combinational path from tready to any output.
module axis_video_src #(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 480,
    parameter int FRAME_GAP = 16
) (
    input  logic        axis_aclk,
    input  logic        axis_areset,
    input  logic        src_enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic [31:0] axis_tdata,
    output logic        axis_tvalid,
    input  logic        axis_tready,
    output logic        axis_tuser,
    output logic        axis_tlast,
    output logic [3:0]  axis_tstrb,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int XW    = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
    localparam int YW    = ($clog2(V_ACTIVE) > 8) ? $clog2(V_ACTIVE) : 8;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;
    localparam int GW    = ($clog2(FRAME_GAP) > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [BW-1:0] bar_cnt, bar_cnt_nxt;
    logic [2:0]    bar_idx, bar_idx_nxt;
    logic [GW-1:0] gap_cnt;
    logic [1:0]    pat_q;
    logic [23:0]   solid_q;
    logic          last_px;

    // Bar colours in left-to-right order.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction

    // Pixel colour for a position; only the low 8 bits of x/y feed the patterns.
    function automatic logic [23:0] pixel_rgb(input logic [1:0] pat, input logic [23:0] solid,
                                              input logic [7:0] px, input logic [7:0] py,
                                              input logic [2:0] bar);
        case (pat)
            2'd0:    pixel_rgb = bar_rgb(bar);
            2'd1:    pixel_rgb = {px, py, 8'(px + py)};
            2'd2:    pixel_rgb = (px[5] ^ py[5]) ? 24'hFFFFFF : 24'h000000;
            default: pixel_rgb = solid;
        endcase
    endfunction

    assign axis_tstrb = 4'hF;
    assign last_px    = (x == X_LAST) && (y == Y_LAST);

    // Position of the pixel following the one currently presented, including bar tracking.
    always_comb begin
        x_nxt       = x + 1'b1;
        y_nxt       = y;
        bar_cnt_nxt = bar_cnt + 1'b1;
        bar_idx_nxt = bar_idx;
        if (x == X_LAST) begin
            x_nxt       = '0;
            y_nxt       = y + 1'b1;
            bar_cnt_nxt = '0;
            bar_idx_nxt = '0;
        end else if (bar_cnt == BAR_LAST) begin
            bar_cnt_nxt = '0;
            bar_idx_nxt = bar_idx + 1'b1;
        end
    end

    // Frame sequencer with registered stream outputs; x/y always name the pixel on the bus.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            gap_cnt     <= '0;
            pat_q       <= '0;
            solid_q     <= '0;
            axis_tdata  <= '0;
            axis_tvalid <= 1'b0;
            axis_tuser  <= 1'b0;
            axis_tlast  <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (src_enable) begin
                        pat_q       <= pattern_sel;
                        solid_q     <= solid_color;
                        x           <= '0;
                        y           <= '0;
                        bar_cnt     <= '0;
                        bar_idx     <= '0;
                        axis_tdata  <= {8'h00, pixel_rgb(pattern_sel, solid_color, 8'h00, 8'h00, 3'd0)};
                        axis_tvalid <= 1'b1;
                        axis_tuser  <= 1'b1;
                        axis_tlast  <= (X_LAST == '0);
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (axis_tvalid && axis_tready) begin
                        if (last_px) begin
                            axis_tvalid <= 1'b0;
                            axis_tuser  <= 1'b0;
                            axis_tlast  <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 1'b1;
                            gap_cnt     <= '0;
                            state       <= (FRAME_GAP == 0) ? IDLE : GAP;
                        end else begin
                            x          <= x_nxt;
                            y          <= y_nxt;
                            bar_cnt    <= bar_cnt_nxt;
                            bar_idx    <= bar_idx_nxt;
                            axis_tdata <= {8'h00, pixel_rgb(pat_q, solid_q, x_nxt[7:0], y_nxt[7:0], bar_idx_nxt)};
                            axis_tuser <= 1'b0;
                            axis_tlast <= (x_nxt == X_LAST);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_video_src.md
Name: axis_video_src

Overview:
- AXI4-Stream video master: the transmitting end of the LCD stream slave interface.
- Generates frames of test-pattern pixels: tuser marks the start of frame, tlast marks the end of each line.
- Drives the LCD pipeline for bring-up without a VDMA, and acts as the reference stimulus source for the LCD path.

Parameters:
- H_ACTIVE, 800, pixels per line (>=8, multiple of 8)
- V_ACTIVE, 480, lines per frame (>=2)
- FRAME_GAP, 16, idle cycles inserted between frames (0 allowed)

Ports:
- axis_aclk  input  1  stream clock; all logic on rising edge
- axis_areset  input  1  asynchronous, active-high reset
- src_enable  input  1  level; 1 = run frames back-to-back
- pattern_sel  input  2  0 colour bars, 1 gradient, 2 checkerboard, 3 solid
- solid_color  input  24  RGB888 value used for pattern 3
- axis_tdata  output  32  pixel {8'h00,R[7:0],G[7:0],B[7:0]}
- axis_tvalid  output  1  pixel valid
- axis_tready  input  1  downstream ready
- axis_tuser  output  1  start of frame (first pixel of the frame only)
- axis_tlast  output  1  last pixel of each line
- axis_tstrb  output  4  constant 4'hF
- frame_done  output  1  one-cycle pulse after the last pixel of a frame transfers
- frame_count  output  16  completed frames, wraps 16'hFFFF->0

Behaviour:
- Reset (async assert, sync release): tvalid=0, tuser=0, tlast=0, tdata=0, frame_done=0, frame_count=0, x=y=0, state=IDLE.
- Transfer occurs when tvalid&&tready.
- While tvalid=1 and tready=0: tdata, tuser and tlast are held stable. tvalid never drops before the transfer completes.
- Output registers load when (!tvalid || tready). Data is registered, so there is no combinational path from tready to any output.
- FSM IDLE: wait for src_enable=1. Then latch pattern_sel and solid_color into frame-local copies, set x=y=0, go to SEND. The first pixel is valid on the next cycle.
- FSM SEND: each transfer advances the pixel position.
  - x increments per transfer. At x=H_ACTIVE-1, x wraps to 0 and y increments.
  - tuser=1 only for the pixel at (0,0).
  - tlast=1 for every pixel with x=H_ACTIVE-1.
  - When the pixel at (H_ACTIVE-1,V_ACTIVE-1) transfers: pulse frame_done for 1 cycle, increment frame_count, go to GAP.
- FSM GAP: tvalid=0 for FRAME_GAP cycles, then go to IDLE. IDLE re-arms on the same cycle if src_enable=1, so the minimum bubble is FRAME_GAP+1 cycles. With FRAME_GAP=0, GAP lasts 0 cycles.
- src_enable deasserted mid-frame: the current frame completes fully. The block never emits a truncated frame.
- pattern_sel/solid_color changed mid-frame: no effect until the next frame start.
- Pattern 0, colour bars: 8 bars, each H_ACTIVE/8 pixels wide.
  - Bar order left to right: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Use a bar-width counter plus a 3-bit bar index. No divider.
- Pattern 1, gradient: R=x[7:0], G=y[7:0], B=(x+y) mod 256.
- Pattern 2, checkerboard: pixel is FFFFFF when x[5]^y[5]=1, else 000000.
- Pattern 3, solid: the latched solid_color on every pixel.
- Counter widths: x and y are $clog2 of H_ACTIVE and V_ACTIVE respectively, minimum 8 bits, zero-extended into pattern arithmetic.
- Reset mid-frame: outputs clear immediately (async). The next frame after release starts with tuser=1 at (0,0).

Test Plan:
- H=8, V=4, GAP=2, pattern 0, tready=1, enable=1:
  - Frame 1: 32 transfers. tuser on beat 0 only. tlast on beats 7,15,23,31.
  - Line data FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,0000FF,000000.
  - frame_done pulses once; frame_count=1.
  - Exactly 3 idle cycles before frame 2's tuser.
- Backpressure: tready random 50% with pattern 1:
  - tdata, tuser and tlast are stable while stalled.
  - Pixel (3,2) = 0x00030205.
  - No beats lost or duplicated; 32 beats per frame.
- Deassert src_enable at beat 10: frame finishes all 32 beats with correct tlast. Then tvalid stays 0 and frame_count=1.
- Pattern 3 with solid_color=123456, switch pattern_sel to 0 at beat 5: whole frame is 0x00123456. The next frame is colour bars.
- Assert axis_areset at beat 13 of a frame: tvalid, tuser and tlast go 0 asynchronously and frame_count=0. After release, the next beat has tuser=1 and the pixel is (0,0).
- frame_count preloaded near wrap by running 65536 frames with H=8, V=2, GAP=0: frame_count wraps to 0.
